// File: rtl/tlb_maint_ctrl.sv
// Sequencer for TLB maintenance ops (TLBP/TLBR/TLBWI/TLBWR); owns Random and Wired.
// Latency: TLBR/TLBWI/TLBWR done 2 cycles after accept, TLBP done 2+k (hit at k) or 33 (miss).
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is dropped, not queued.
// Optional build macro TLB_PROBE_MULTI_HIT_EN: full 32-entry probe scan with a multi_hit flag.
module tlb_maint_ctrl #(
    parameter int ENTRIES = 32,
    parameter int HDR_W   = 44,
    parameter int ENT_W   = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             done,
    input  logic [4:0]       index_in,
    input  logic [HDR_W-1:0] header_in,
    input  logic [ENT_W-1:0] entry_in,
    input  logic             wired_we,
    input  logic [4:0]       wired_in,
    output logic [4:0]       random,
    output logic [4:0]       wired,
    output logic [4:0]       probe_index,
    output logic             probe_miss,
`ifdef TLB_PROBE_MULTI_HIT_EN
    output logic             multi_hit,
`endif
    output logic [HDR_W-1:0] rd_header,
    output logic [ENT_W-1:0] rd_entry,
    output logic [4:0]       tlb_indexC,
    input  logic [HDR_W-1:0] tlb_headerC,
    input  logic [ENT_W-1:0] tlb_entryC,
    output logic [4:0]       tlb_indexD,
    input  logic [HDR_W-1:0] tlb_headerD,
    output logic             tlb_we,
    output logic [ENT_W-1:0] tlb_dataIn,
    output logic [HDR_W-1:0] tlb_headerIn
);

    localparam logic [4:0] LAST_IDX = 5'(ENTRIES - 1);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t            state;
    logic [HDR_W-1:0]  key_q;
    logic [ENT_W-1:0]  ent_q;

    // Probe compare against the entry currently addressed on port D.
    // Stored PageMask[16:1] widens the page, so those VPN2 bits are don't-care.
    logic [18:0] vpn_mask;
    logic        vpn_hit;
    logic        asid_hit;
    logic        probe_hit;

    assign vpn_mask  = {3'b000, tlb_headerD[16:1]};
    assign vpn_hit   = ((tlb_headerD[43:25] ^ key_q[43:25]) & ~vpn_mask) == 19'd0;
    assign asid_hit  = tlb_headerD[0] | (tlb_headerD[24:17] == key_q[24:17]);
    assign probe_hit = vpn_hit & asid_hit;

    assign cmd_ready    = (state == IDLE);
    assign tlb_dataIn   = ent_q;
    assign tlb_headerIn = key_q;

    // Wired register: software-loaded lower bound for Random.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wired <= 5'd0;
        end else if (wired_we) begin
            wired <= wired_in;
        end
    end

    // Random register: free-running down-counter that wraps from wired back to the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random <= LAST_IDX;
        end else if (wired_we) begin
            random <= LAST_IDX;
        end else if (random == wired) begin
            random <= LAST_IDX;
        end else begin
            random <= random - 5'd1;
        end
    end

`ifdef TLB_PROBE_MULTI_HIT_EN
    logic       found_q;
    logic [4:0] first_q;
    logic       dup_q;
    logic       hit_any;
    logic [4:0] first_idx;

    assign hit_any   = found_q | probe_hit;
    assign first_idx = found_q ? first_q : tlb_indexD;
`endif

    // Command sequencer; tlb_indexD doubles as the probe scan pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            done        <= 1'b0;
            tlb_we      <= 1'b0;
            probe_index <= 5'd0;
            probe_miss  <= 1'b0;
            rd_header   <= '0;
            rd_entry    <= '0;
            tlb_indexC  <= 5'd0;
            tlb_indexD  <= 5'd0;
            key_q       <= '0;
            ent_q       <= '0;
`ifdef TLB_PROBE_MULTI_HIT_EN
            multi_hit   <= 1'b0;
            found_q     <= 1'b0;
            first_q     <= 5'd0;
            dup_q       <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            tlb_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        key_q <= header_in;
                        ent_q <= entry_in;
                        case (cmd_op)
                            OP_TLBP: begin
                                state      <= PROBE;
                                tlb_indexD <= 5'd0;
`ifdef TLB_PROBE_MULTI_HIT_EN
                                found_q    <= 1'b0;
                                dup_q      <= 1'b0;
`endif
                            end
                            OP_TLBR: begin
                                state      <= READ;
                                tlb_indexC <= index_in;
                            end
                            OP_TLBWI: begin
                                state      <= WRITE;
                                tlb_indexD <= index_in;
                                tlb_we     <= 1'b1;
                            end
                            default: begin
                                // TLBWR target is Random as it stands at the accept edge.
                                state      <= WRITE;
                                tlb_indexD <= random;
                                tlb_we     <= 1'b1;
                            end
                        endcase
                    end
                end
                PROBE: begin
`ifdef TLB_PROBE_MULTI_HIT_EN
                    if (probe_hit && !found_q) begin
                        found_q <= 1'b1;
                        first_q <= tlb_indexD;
                    end
                    if (probe_hit && found_q) begin
                        dup_q <= 1'b1;
                    end
                    if (tlb_indexD == LAST_IDX) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        multi_hit <= dup_q | (probe_hit & found_q);
                        if (hit_any) begin
                            probe_index <= first_idx;
                            probe_miss  <= 1'b0;
                        end else begin
                            probe_miss  <= 1'b1;
                        end
                    end else begin
                        tlb_indexD <= tlb_indexD + 5'd1;
                    end
`else
                    if (probe_hit) begin
                        state       <= IDLE;
                        done        <= 1'b1;
                        probe_index <= tlb_indexD;
                        probe_miss  <= 1'b0;
                    end else if (tlb_indexD == LAST_IDX) begin
                        state      <= IDLE;
                        done       <= 1'b1;
                        probe_miss <= 1'b1;
                    end else begin
                        tlb_indexD <= tlb_indexD + 5'd1;
                    end
`endif
                end
                READ: begin
                    state     <= IDLE;
                    done      <= 1'b1;
                    rd_header <= tlb_headerC;
                    rd_entry  <= tlb_entryC;
                end
                default: begin
                    // WRITE: storage commits at this edge; tlb_we drops with it.
                    state <= IDLE;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
module tb_tlb_maint_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        done;
    logic [4:0]  index_in;
    logic [43:0] header_in;
    logic [49:0] entry_in;
    logic        wired_we;
    logic [4:0]  wired_in;
    logic [4:0]  random;
    logic [4:0]  wired;
    logic [4:0]  probe_index;
    logic        probe_miss;
`ifdef TLB_PROBE_MULTI_HIT_EN
    logic        multi_hit;
`endif
    logic [43:0] rd_header;
    logic [49:0] rd_entry;
    logic [4:0]  tlb_indexC;
    logic [43:0] tlb_headerC;
    logic [49:0] tlb_entryC;
    logic [4:0]  tlb_indexD;
    logic [43:0] tlb_headerD;
    logic        tlb_we;
    logic [49:0] tlb_dataIn;
    logic [43:0] tlb_headerIn;

    int n_pass = 0;
    int n_total = 0;

`ifdef TLB_PROBE_MULTI_HIT_EN
    localparam int LAT_HIT7 = 33;
    localparam int LAT_HIT3 = 33;
`else
    localparam int LAT_HIT7 = 9;
    localparam int LAT_HIT3 = 5;
`endif

    always #5 clk = ~clk;

    tlb_maint_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready), .done(done),
        .index_in(index_in), .header_in(header_in), .entry_in(entry_in),
        .wired_we(wired_we), .wired_in(wired_in), .random(random), .wired(wired),
        .probe_index(probe_index), .probe_miss(probe_miss),
`ifdef TLB_PROBE_MULTI_HIT_EN
        .multi_hit(multi_hit),
`endif
        .rd_header(rd_header), .rd_entry(rd_entry),
        .tlb_indexC(tlb_indexC), .tlb_headerC(tlb_headerC), .tlb_entryC(tlb_entryC),
        .tlb_indexD(tlb_indexD), .tlb_headerD(tlb_headerD), .tlb_we(tlb_we),
        .tlb_dataIn(tlb_dataIn), .tlb_headerIn(tlb_headerIn)
    );

    function automatic logic [43:0] mk_hdr(input logic [18:0] vpn, input logic [7:0] asid,
                                           input logic [15:0] mask, input logic g);
        return {vpn, asid, mask, g};
    endfunction

    // Storage array model: combinational reads on ports C and D, write at clock edge.
    logic [43:0] mem_h [32];
    logic [49:0] mem_e [32];
    logic        mem_clr;
    int          wr_cnt;
    logic [4:0]  last_wr;

    assign tlb_headerC = mem_h[tlb_indexC];
    assign tlb_entryC  = mem_e[tlb_indexC];
    assign tlb_headerD = mem_h[tlb_indexD];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) begin
                mem_h[i] <= mk_hdr(19'(32'h70000 + i), 8'h00, 16'h0000, 1'b0);
                mem_e[i] <= '0;
            end
            wr_cnt  <= 0;
            last_wr <= 5'd0;
        end else if (tlb_we) begin
            mem_h[tlb_indexD] <= tlb_headerIn;
            mem_e[tlb_indexD] <= tlb_dataIn;
            wr_cnt  <= wr_cnt + 1;
            last_wr <= tlb_indexD;
        end
    end

    // Issue one command and return cycles from accept edge T to the edge where done is sampled.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] idx, input logic [43:0] hdr,
                           input logic [49:0] ent, output int lat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; index_in = idx; header_in = hdr; entry_in = ent;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (done) lat = n + 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        #1;
        n_total++; if (random !== 5'd31) $display("FAIL reset_random got %0d want 31", random); else n_pass++;
        n_total++; if (wired !== 5'd0) $display("FAIL reset_wired got %0d want 0", wired); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_total++; if (tlb_we !== 1'b0) $display("FAIL reset_tlb_we got %b want 0", tlb_we); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else n_pass++;
        n_total++; if (probe_index !== 5'd0 || probe_miss !== 1'b0) $display("FAIL reset_probe got %0d/%b want 0/0", probe_index, probe_miss); else n_pass++;
        n_total++; if (rd_header !== 44'd0 || rd_entry !== 50'd0) $display("FAIL reset_rd got %h/%h want 0/0", rd_header, rd_entry); else n_pass++;
        n_total++; if (tlb_indexC !== 5'd0 || tlb_indexD !== 5'd0) $display("FAIL reset_indexes got %0d/%0d want 0/0", tlb_indexC, tlb_indexD); else n_pass++;
`ifdef TLB_PROBE_MULTI_HIT_EN
        n_total++; if (multi_hit !== 1'b0) $display("FAIL reset_multi_hit got %b want 0", multi_hit); else n_pass++;
`endif
    endtask

    task automatic test_random_count();
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            n_total++; if (random !== 5'(31 - i)) $display("FAIL random_count step %0d got %0d want %0d", i, random, 31 - i); else n_pass++;
        end
        repeat (27) @(posedge clk);
        #1;
        n_total++; if (random !== 5'd0) $display("FAIL random_floor got %0d want 0", random); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (random !== 5'd31) $display("FAIL random_wrap got %0d want 31", random); else n_pass++;
    endtask

    task automatic test_wired();
        logic [4:0] exp_seq [3];
        exp_seq[0] = 5'd30; exp_seq[1] = 5'd29; exp_seq[2] = 5'd31;
        @(negedge clk); wired_we = 1'b1; wired_in = 5'd29;
        @(posedge clk); #1 wired_we = 1'b0;
        n_total++; if (random !== 5'd31 || wired !== 5'd29) $display("FAIL wired_load got %0d/%0d want 31/29", random, wired); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++; if (random !== exp_seq[i]) $display("FAIL wired29_seq step %0d got %0d want %0d", i, random, exp_seq[i]); else n_pass++;
        end
        @(negedge clk); wired_we = 1'b1; wired_in = 5'd31;
        @(posedge clk); #1 wired_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++; if (random !== 5'd31) $display("FAIL wired31_pin step %0d got %0d want 31", i, random); else n_pass++;
        end
    endtask

    task automatic test_write_read();
        int lat;
        int w0;
        logic [43:0] h7;
        logic [49:0] e7;
        h7 = mk_hdr(19'h12345, 8'h05, 16'h0000, 1'b0);
        e7 = 50'h2AAAA5555;
        w0 = wr_cnt;
        run_cmd(2'b10, 5'd7, h7, e7, lat);
        n_total++; if (lat !== 2) $display("FAIL tlbwi_latency got %0d want 2", lat); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (done !== 1'b0) $display("FAIL tlbwi_done_pulse got %b want 0", done); else n_pass++;
        n_total++; if (wr_cnt !== w0 + 1) $display("FAIL tlbwi_we_cycles got %0d want 1", wr_cnt - w0); else n_pass++;
        n_total++; if (last_wr !== 5'd7) $display("FAIL tlbwi_index got %0d want 7", last_wr); else n_pass++;
        n_total++; if (mem_h[7] !== h7 || mem_e[7] !== e7) $display("FAIL tlbwi_data got %h/%h want %h/%h", mem_h[7], mem_e[7], h7, e7); else n_pass++;
        run_cmd(2'b01, 5'd7, 44'd0, 50'd0, lat);
        n_total++; if (lat !== 2) $display("FAIL tlbr_latency got %0d want 2", lat); else n_pass++;
        n_total++; if (rd_header !== h7 || rd_entry !== e7) $display("FAIL tlbr_data got %h/%h want %h/%h", rd_header, rd_entry, h7, e7); else n_pass++;
    endtask

    task automatic test_probe();
        int lat;
        run_cmd(2'b00, 5'd0, mk_hdr(19'h12345, 8'h05, 16'h0000, 1'b0), 50'd0, lat);
        n_total++; if (probe_index !== 5'd7 || probe_miss !== 1'b0) $display("FAIL probe_hit7 got %0d/%b want 7/0", probe_index, probe_miss); else n_pass++;
        n_total++; if (lat !== LAT_HIT7) $display("FAIL probe_hit7_latency got %0d want %0d", lat, LAT_HIT7); else n_pass++;
`ifdef TLB_PROBE_MULTI_HIT_EN
        n_total++; if (multi_hit !== 1'b0) $display("FAIL probe_single_multi got %b want 0", multi_hit); else n_pass++;
`endif
        run_cmd(2'b00, 5'd0, mk_hdr(19'h12345, 8'h06, 16'h0000, 1'b0), 50'd0, lat);
        n_total++; if (probe_miss !== 1'b1 || probe_index !== 5'd7) $display("FAIL probe_asid_miss got %0d/%b want 7/1", probe_index, probe_miss); else n_pass++;
        n_total++; if (lat !== 33) $display("FAIL probe_miss_latency got %0d want 33", lat); else n_pass++;
        run_cmd(2'b10, 5'd7, mk_hdr(19'h12345, 8'h05, 16'h0000, 1'b1), 50'h2AAAA5555, lat);
        run_cmd(2'b00, 5'd0, mk_hdr(19'h12345, 8'h06, 16'h0000, 1'b0), 50'd0, lat);
        n_total++; if (probe_index !== 5'd7 || probe_miss !== 1'b0) $display("FAIL probe_global got %0d/%b want 7/0", probe_index, probe_miss); else n_pass++;
        n_total++; if (lat !== LAT_HIT7) $display("FAIL probe_global_latency got %0d want %0d", lat, LAT_HIT7); else n_pass++;
    endtask

    task automatic test_lowest_match();
        int lat;
        // Entry 3 matches only through its PageMask (VPN2[3:0] don't-care); entry 9 matches exactly.
        run_cmd(2'b10, 5'd3, mk_hdr(19'h0ABC0, 8'h22, 16'h000F, 1'b0), 50'h1, lat);
        run_cmd(2'b10, 5'd9, mk_hdr(19'h0ABCD, 8'h22, 16'h0000, 1'b0), 50'h2, lat);
        run_cmd(2'b00, 5'd0, mk_hdr(19'h0ABCD, 8'h22, 16'h0000, 1'b0), 50'd0, lat);
        n_total++; if (probe_index !== 5'd3 || probe_miss !== 1'b0) $display("FAIL lowest_match got %0d/%b want 3/0", probe_index, probe_miss); else n_pass++;
        n_total++; if (lat !== LAT_HIT3) $display("FAIL lowest_match_latency got %0d want %0d", lat, LAT_HIT3); else n_pass++;
`ifdef TLB_PROBE_MULTI_HIT_EN
        n_total++; if (multi_hit !== 1'b1) $display("FAIL multi_hit got %b want 1", multi_hit); else n_pass++;
`endif
        // VPN2 bit 4 lies outside entry 3's mask, so nothing matches.
        run_cmd(2'b00, 5'd0, mk_hdr(19'h0ABDD, 8'h22, 16'h0000, 1'b0), 50'd0, lat);
        n_total++; if (probe_miss !== 1'b1 || probe_index !== 5'd3) $display("FAIL mask_boundary got %0d/%b want 3/1", probe_index, probe_miss); else n_pass++;
`ifdef TLB_PROBE_MULTI_HIT_EN
        n_total++; if (multi_hit !== 1'b0) $display("FAIL multi_hit_clear got %b want 0", multi_hit); else n_pass++;
`endif
    endtask

    task automatic test_tlbwr();
        logic        seen;
        logic [43:0] hw;
        hw = mk_hdr(19'h55555, 8'h33, 16'h0000, 1'b0);
        @(negedge clk); wired_we = 1'b1; wired_in = 5'd0;
        @(posedge clk); #1 wired_we = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (random == 5'd12) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b1) $display("FAIL tlbwr_wait_random12 got %0d want 12", random); else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b11; index_in = 5'd2; header_in = hw; entry_in = 50'h3C3C3;
        wired_we = 1'b1; wired_in = 5'd5;
        @(posedge clk);
        #1 cmd_valid = 1'b0; wired_we = 1'b0;
        n_total++; if (random !== 5'd31 || wired !== 5'd5) $display("FAIL tlbwr_random_reload got %0d/%0d want 31/5", random, wired); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done !== 1'b1) $display("FAIL tlbwr_done got %b want 1", done); else n_pass++;
        n_total++; if (random !== 5'd30) $display("FAIL tlbwr_random_next got %0d want 30", random); else n_pass++;
        n_total++; if (last_wr !== 5'd12 || mem_h[12] !== hw) $display("FAIL tlbwr_target got %0d/%h want 12/%h", last_wr, mem_h[12], hw); else n_pass++;
    endtask

    task automatic test_busy_ignored();
        int lat;
        int w0;
        w0 = wr_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; header_in = mk_hdr(19'h7FFFF, 8'h99, 16'h0000, 1'b0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL busy_ready got %b want 0", cmd_ready); else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; index_in = 5'd20;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        for (int n = 2; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (done) lat = n + 1;
        end
        n_total++; if (lat !== 33 || probe_miss !== 1'b1) $display("FAIL busy_probe got lat %0d miss %b want 33/1", lat, probe_miss); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (wr_cnt !== w0) $display("FAIL busy_cmd_dropped got %0d writes want 0", wr_cnt - w0); else n_pass++;
    endtask

    task automatic test_reset_mid_probe();
        logic seen;
        int   w0;
        int   dones;
        w0 = wr_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; header_in = mk_hdr(19'h7FFFF, 8'h99, 16'h0000, 1'b0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        seen = (tlb_indexD == 5'd10);
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (tlb_indexD == 5'd10) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b1) $display("FAIL rst_mid_reach_ptr10 got %0d want 10", tlb_indexD); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (done !== 1'b0 || tlb_we !== 1'b0) $display("FAIL rst_mid_outputs got done %b we %b want 0/0", done, tlb_we); else n_pass++;
        n_total++; if (random !== 5'd31) $display("FAIL rst_mid_random got %0d want 31", random); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", cmd_ready); else n_pass++;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        n_total++; if (dones !== 0 || wr_cnt !== w0) $display("FAIL rst_mid_no_completion got %0d dones %0d writes want 0/0", dones, wr_cnt - w0); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_clr = 1'b1;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; index_in = 5'd0;
        header_in = '0; entry_in = '0;
        wired_we = 1'b0; wired_in = 5'd0;
        test_reset();
        test_random_count();
        test_wired();
        test_write_read();
        test_probe();
        test_lowest_match();
        test_tlbwr();
        test_busy_ignored();
        test_reset_mid_probe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tlb_maint_ctrl.md
Name: tlb_maint_ctrl

Overview:
Sequencer for CP0 TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR). Sits beside the 32-entry TLB storage array and drives its port C (read) and port D (probe/write) addresses, write enable and write data. Owns the Random register and the Wired register. Returns probe and read results to CP0.

Parameters:
ENTRIES, 32, TLB entry count; index width fixed at 5 bits.
HDR_W, 44, header width: [43:25] VPN2, [24:17] ASID, [16:1] PageMask, [0] G.
ENT_W, 50, entry width: [49:25] EntryLo0, [24:0] EntryLo1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  maintenance request
cmd_op  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
cmd_ready  out  1  high only in IDLE
done  out  1  one-cycle completion pulse
index_in  in  5  CP0 Index register
header_in  in  44  EntryHi/PageMask/G image; also the probe key
entry_in  in  50  EntryLo0/EntryLo1 image
wired_we  in  1  Wired register write strobe
wired_in  in  5  new Wired value
random  out  5  Random register
wired  out  5  Wired register
probe_index  out  5  index of matching entry
probe_miss  out  1  Index.P bit
rd_header  out  44  TLBR header result
rd_entry  out  50  TLBR entry result
tlb_indexC  out  5  storage read address
tlb_headerC  in  44  storage header read data, combinational
tlb_entryC  in  50  storage entry read data, combinational
tlb_indexD  out  5  storage probe/write address
tlb_headerD  in  44  storage header read data at indexD, combinational
tlb_we  out  1  storage write enable
tlb_dataIn  out  50  storage entry write data
tlb_headerIn  out  44  storage header write data

Behaviour:
- Reset values: state IDLE; random=31; wired=0; done=0; tlb_we=0; probe_index=0; probe_miss=0; rd_header=0; rd_entry=0; tlb_indexC=0; tlb_indexD=0.
- Reset asserted mid-operation aborts the operation. No write is issued. No done pulse.
- States: IDLE, PROBE, READ, WRITE.
- Accept: a command is accepted at edge T when cmd_valid and cmd_ready are both high. At accept, latch op, index_in, header_in and entry_in. For TLBWR, the write index is the value of random at edge T.
- TLBP: enter PROBE with ptr=0; tlb_indexD=ptr.
  - Each cycle, compare tlb_headerD against the latched key.
  - VPN2 match: bits [43:25] equal, except bits masked by stored PageMask[16:1] mapped onto VPN2[15:0]. Masked bits compare as equal.
  - ASID: entry must have G=1, or stored ASID equal to key ASID.
  - Hit at ptr=k: probe_index=k, probe_miss=0, return to IDLE. done is high in cycle T+2+k.
  - No hit by ptr=31: probe_miss=1, probe_index unchanged, done at T+33.
  - Lowest matching index wins.
- TLBR: READ for one cycle with tlb_indexC=latched index. Capture tlb_headerC/tlb_entryC into rd_header/rd_entry. done at T+2.
- TLBWI/TLBWR: WRITE for one cycle. tlb_indexD=target, tlb_we=1, tlb_dataIn/tlb_headerIn=latched data. done at T+2. tlb_we is never high outside WRITE.
- Random register: updates every cycle.
  - If wired_we: random=31.
  - Else if random==wired: random=31.
  - Else: random=random-1.
- Random wraps from wired to 31, never below wired. wired_in=31 pins random at 31.
- Wired register: loads wired_in on wired_we. A wired_we during a pending TLBWR does not change the latched write index.
- cmd_valid while not ready is ignored and not queued.
- Outside PROBE/WRITE, tlb_indexD holds its last value.

Optional Feature:
TLB_PROBE_MULTI_HIT_EN. When defined:
- Adds output multi_hit (1 bit, reset 0).
- TLBP always scans all 32 entries; done at T+33 regardless of hit.
- probe_index is the lowest match.
- multi_hit=1 if two or more entries match, else 0; updated at each TLBP completion.

When undefined: early exit on first hit as above; no multi_hit port.

Test Plan:
1. Reset, then idle 5 cycles with wired=0 -> random reads 31,30,29,28,27. After 32 cycles from reset, random reads 31 again.
2. wired_we with wired_in=29, then 3 idle cycles -> random 31,30,29,31. Set wired_in=31 -> random stays 31.
3. TLBWI with index_in=7, header VPN2=0x12345, ASID=0x05, G=0, entry 0x2AAAA_5555 -> tlb_we high exactly one cycle with tlb_indexD=7. Then TLBR with index 7 -> rd_header/rd_entry equal the written values, done at T+2.
4. TLBP with key VPN2=0x12345, ASID=0x05 -> probe_index=7, probe_miss=0, done at T+9. Same key with ASID=0x06 -> probe_miss=1, done at T+33. After rewriting entry 7 with G=1 -> hit.
5. TLBWR issued when random=12 while wired_we fires in the same cycle -> write lands at index 12; random becomes 31 next cycle.
6. Assert rst_n low during PROBE at ptr=10 -> no done pulse, tlb_we=0, random=31, cmd_ready=1 after release.
   With TLB_PROBE_MULTI_HIT_EN: entries 3 and 9 both matching -> probe_index=3, multi_hit=1, done at T+33.
